// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and counter widths for fifo_write_arbiter
package fifo_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} arb_state_e;
  localparam int CNT_W = 4;
  localparam int STAT_W = 16;
endpackage

// File: rtl/fifo_arb_sat_counter.sv
// fifo_arb_sat_counter: enable-driven counter that sticks at all-ones
module fifo_arb_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q, count_d;
  // advance on enable unless already at the ceiling
  always_comb count_d = (en_i && count_q != '1) ? count_q + 1'b1 : count_q;
  // count register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) count_q <= '0;
    else count_q <= count_d;
  assign count_o = count_q;
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: two-requester burst-limited round-robin FIFO writer; FIFO_ARB_STATS_EN adds per-requester accept counters
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  ipClk,
  input  logic                  ipReset,
  input  logic                  ipValid0,
  input  logic                  ipValid1,
  input  logic [DATA_WIDTH-1:0] ipData0,
  input  logic [DATA_WIDTH-1:0] ipData1,
  output logic                  opReady0,
  output logic                  opReady1,
  input  logic                  ipFIFOFull,
  output logic                  opWriteEnable,
  output logic [DATA_WIDTH-1:0] opWriteData,
  output logic [1:0]            opGrant
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]     opCount0,
  output logic [STAT_W-1:0]     opCount1
`endif
);
  localparam logic [CNT_W-1:0] BL = CNT_W'(BURST_LEN);
  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             last_q, last_d;
  logic             own_v, oth_v;
  assign own_v   = state_q == GRANT0 ? ipValid0 : ipValid1;
  assign oth_v   = state_q == GRANT0 ? ipValid1 : ipValid0;
  assign cnt_inc = (own_v && cnt_q != BL) ? cnt_q + 1'b1 : cnt_q;
  // state, burst counter and last-owner registers; last-owner 1 lets requester 0 win the first tie
  always_ff @(posedge ipClk or posedge ipReset)
    if (ipReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  // next state: ownership only moves on unstalled cycles, so a full FIFO freezes everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (state_q == IDLE) begin
      state_d = (ipValid0 && (!ipValid1 || last_q)) ? GRANT0 : ipValid1 ? GRANT1 : IDLE;
      cnt_d   = '0;
    end else if (!ipFIFOFull) begin
      if (!own_v || (cnt_inc == BL && oth_v)) begin
        state_d = !oth_v ? IDLE : state_q == GRANT0 ? GRANT1 : GRANT0;
        cnt_d   = '0;
        last_d  = state_q == GRANT1;
      end else cnt_d = cnt_inc;
    end
  end
  // outputs: handshake and write path are combinational from the owner's inputs
  always_comb begin
    opGrant       = {state_q == GRANT1, state_q == GRANT0};
    opReady0      = state_q == GRANT0 && !ipFIFOFull;
    opReady1      = state_q == GRANT1 && !ipFIFOFull;
    opWriteEnable = (opReady0 && ipValid0) || (opReady1 && ipValid1);
    opWriteData   = state_q == GRANT0 ? ipData0 : state_q == GRANT1 ? ipData1 : '0;
  end
`ifdef FIFO_ARB_STATS_EN
  fifo_arb_sat_counter #(.WIDTH(STAT_W)) u_cnt0 (
    .clk_i(ipClk), .rst_i(ipReset), .en_i(opReady0 && ipValid0), .count_o(opCount0)
  );
  fifo_arb_sat_counter #(.WIDTH(STAT_W)) u_cnt1 (
    .clk_i(ipClk), .rst_i(ipReset), .en_i(opReady1 && ipValid1), .count_o(opCount1)
  );
`endif
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: randomized and directed checks of fifo_write_arbiter against a requester-level model
module tb_fifo_write_arbiter;
  localparam int BL = 4;
  logic       ipClk = 1'b0;
  logic       ipReset = 1'b1;
  logic       ipValid0 = 1'b0, ipValid1 = 1'b0, ipFIFOFull = 1'b0;
  logic [7:0] ipData0 = '0, ipData1 = '0;
  logic       opReady0, opReady1, opWriteEnable;
  logic [7:0] opWriteData;
  logic [1:0] opGrant;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] opCount0, opCount1;
`endif
  int n_cmp = 0, n_bad = 0;
  int owner = -1, burst = 0, prev = 1;
  logic [1:0] eg;
  logic       er0, er1, ewe;
  logic [7:0] ewd;

  fifo_write_arbiter #(.DATA_WIDTH(8), .BURST_LEN(BL)) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipValid0(ipValid0), .ipValid1(ipValid1),
    .ipData0(ipData0), .ipData1(ipData1), .opReady0(opReady0), .opReady1(opReady1),
    .ipFIFOFull(ipFIFOFull), .opWriteEnable(opWriteEnable), .opWriteData(opWriteData),
    .opGrant(opGrant)
`ifdef FIFO_ARB_STATS_EN
    , .opCount0(opCount0), .opCount1(opCount1)
`endif
  );

  always #5 ipClk = ~ipClk;

  task automatic sample();
    @(negedge ipClk);
    if (ipReset || owner < 0) {eg, er0, er1, ewe, ewd} = '0;
    else begin
      eg  = owner == 0 ? 2'b01 : 2'b10;
      er0 = owner == 0 && !ipFIFOFull;
      er1 = owner == 1 && !ipFIFOFull;
      ewe = (owner == 0 ? ipValid0 : ipValid1) && !ipFIFOFull;
      ewd = owner == 0 ? ipData0 : ipData1;
    end
  endtask

  task automatic advance();
    logic ov, tv;
    @(posedge ipClk);
    ov = owner == 0 ? ipValid0 : ipValid1;
    tv = owner == 0 ? ipValid1 : ipValid0;
    if (ipReset) begin
      owner = -1; burst = 0; prev = 1;
    end else if (owner < 0) begin
      if (ipValid0 || ipValid1) begin
        owner = (ipValid0 && ipValid1) ? 1 - prev : (ipValid0 ? 0 : 1);
        burst = 0;
      end
    end else if (!ipFIFOFull) begin
      if (!ov) begin
        prev = owner; owner = tv ? 1 - owner : -1; burst = 0;
      end else begin
        burst = burst < BL ? burst + 1 : BL;
        if (burst == BL && tv) begin prev = owner; owner = 1 - owner; burst = 0; end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    ipReset = 1'b1; ipValid0 = 0; ipValid1 = 0; ipFIFOFull = 0;
    advance();
    ipReset = 1'b0;
  endtask

  task automatic test_reset();
    ipReset = 1'b1; ipValid0 = 1; ipValid1 = 1; ipData0 = 8'hAA; ipData1 = 8'h55;
    sample();
    n_cmp++;
    if ({opGrant, opReady1, opReady0, opWriteEnable, opWriteData} !== 13'd0) begin
      n_bad++; $display("FAIL reset outputs got %b/%h want 0", {opGrant, opReady1, opReady0, opWriteEnable}, opWriteData);
    end
    advance();
    ipReset = 1'b0; ipValid0 = 0; ipValid1 = 0;
  endtask

  task automatic test_single_stream();
    logic [7:0] got[$];
    int c, ok;
    do_reset();
    ipValid0 = 1;
    for (c = 0; c < 40 && got.size() < 32; c++) begin
      ipData0 = 8'(got.size());
      sample();
      n_cmp++;
      if ({opGrant, opReady1, opReady0, opWriteEnable, opWriteData} !== {eg, er1, er0, ewe, ewd}) begin
        n_bad++; $display("FAIL single cyc%0d got %b/%h want %b/%h", c, {opGrant, opReady1, opReady0, opWriteEnable}, opWriteData, {eg, er1, er0, ewe}, ewd);
      end
      if (opWriteEnable) got.push_back(opWriteData);
      advance();
    end
    ipValid0 = 0;
    ok = got.size() == 32 && c == 33;
    foreach (got[i]) if (got[i] !== 8'(i)) ok = 0;
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL single_order got %0d words in %0d cycles want 32 in 33", got.size(), c); end
  endtask

  task automatic test_round_robin();
    logic [7:0] seq[$];
    int c, ok, k0, k1, idx;
    do_reset();
    ipValid0 = 1; ipValid1 = 1; k0 = 0; k1 = 0;
    for (c = 0; c < 40 && seq.size() < 32; c++) begin
      ipData0 = 8'(k0); ipData1 = 8'h80 | 8'(k1);
      sample();
      n_cmp++;
      if ({opGrant, opReady1, opReady0, opWriteEnable, opWriteData} !== {eg, er1, er0, ewe, ewd}) begin
        n_bad++; $display("FAIL rr cyc%0d got %b/%h want %b/%h", c, {opGrant, opReady1, opReady0, opWriteEnable}, opWriteData, {eg, er1, er0, ewe}, ewd);
      end
      if (opWriteEnable) begin
        seq.push_back(opWriteData);
        if (opWriteData[7]) k1++; else k0++;
      end
      advance();
    end
    ipValid0 = 0; ipValid1 = 0;
    ok = seq.size() == 32 && c == 33;
    foreach (seq[i]) begin
      idx = (i / 8) * 4 + i % 4;
      if (seq[i] !== (((i / 4) % 2) ? (8'h80 | 8'(idx)) : 8'(idx))) ok = 0;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rr_pattern got %0d words in %0d cycles want 4x alternating 32 in 33", seq.size(), c); end
  endtask

  task automatic test_full_stall();
    logic [7:0] seq[$];
    int c, ok, k0, k1, idx;
    do_reset();
    ipValid0 = 1; ipValid1 = 1; k0 = 0; k1 = 0;
    for (c = 0; c < 30 && seq.size() < 12; c++) begin
      ipData0 = 8'(k0); ipData1 = 8'h80 | 8'(k1);
      ipFIFOFull = c >= 3 && c < 8;
      sample();
      n_cmp++;
      if ({opGrant, opReady1, opReady0, opWriteEnable, opWriteData} !== {eg, er1, er0, ewe, ewd}) begin
        n_bad++; $display("FAIL stall cyc%0d got %b/%h want %b/%h", c, {opGrant, opReady1, opReady0, opWriteEnable}, opWriteData, {eg, er1, er0, ewe}, ewd);
      end
      if (ipFIFOFull) begin
        n_cmp++;
        if ({opGrant, opReady1, opReady0, opWriteEnable} !== 5'b01000) begin
          n_bad++; $display("FAIL stall_hold cyc%0d got %b want 01000", c, {opGrant, opReady1, opReady0, opWriteEnable});
        end
      end
      if (opWriteEnable) begin
        seq.push_back(opWriteData);
        if (opWriteData[7]) k1++; else k0++;
      end
      advance();
    end
    ipValid0 = 0; ipValid1 = 0; ipFIFOFull = 0;
    ok = seq.size() == 12 && c == 18;
    foreach (seq[i]) begin
      idx = (i / 8) * 4 + i % 4;
      if (seq[i] !== (((i / 4) % 2) ? (8'h80 | 8'(idx)) : 8'(idx))) ok = 0;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL stall_resume got %0d words in %0d cycles want 12 in 18", seq.size(), c); end
  endtask

  task automatic test_reset_mid_burst();
    logic [2:0] tbl[8] = '{3'b010, 3'b010, 3'b000, 3'b001, 3'b001, 3'b101, 3'b011, 3'b011};
    do_reset();
    for (int s = 0; s < 8; s++) begin
      {ipReset, ipValid0, ipValid1} = tbl[s];
      ipData0 = 8'h10 + 8'(s); ipData1 = 8'h20 + 8'(s);
      sample();
      n_cmp++;
      if ({opGrant, opReady1, opReady0, opWriteEnable, opWriteData} !== {eg, er1, er0, ewe, ewd}) begin
        n_bad++; $display("FAIL rstmid step%0d got %b/%h want %b/%h", s, {opGrant, opReady1, opReady0, opWriteEnable}, opWriteData, {eg, er1, er0, ewe}, ewd);
      end
      if (s == 5) begin
        n_cmp++;
        if ({opGrant, opReady1, opReady0, opWriteEnable, opWriteData} !== 13'd0) begin
          n_bad++; $display("FAIL rstmid_zero got %b/%h want 0", {opGrant, opReady1, opReady0, opWriteEnable}, opWriteData);
        end
      end
      if (s == 7) begin
        n_cmp++;
        if (opGrant !== 2'b01) begin n_bad++; $display("FAIL rstmid_tie got grant %b want 01", opGrant); end
      end
      advance();
    end
    ipReset = 0; ipValid0 = 0; ipValid1 = 0;
  endtask

  task automatic test_rotation();
    int first0 = -1;
    do_reset();
    ipValid1 = 1;
    for (int c = 0; c < 20; c++) begin
      ipValid0 = c >= 11;
      ipData0 = 8'h40 + 8'(c); ipData1 = 8'hC0 + 8'(c);
      sample();
      n_cmp++;
      if ({opGrant, opReady1, opReady0, opWriteEnable, opWriteData} !== {eg, er1, er0, ewe, ewd}) begin
        n_bad++; $display("FAIL rot cyc%0d got %b/%h want %b/%h", c, {opGrant, opReady1, opReady0, opWriteEnable}, opWriteData, {eg, er1, er0, ewe}, ewd);
      end
      if (first0 < 0 && opGrant == 2'b01) first0 = c;
      advance();
    end
    ipValid0 = 0; ipValid1 = 0;
    n_cmp++;
    if (first0 < 11 || first0 > 13) begin n_bad++; $display("FAIL rot_next first r0 grant at cycle %0d want 11..13", first0); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      ipReset    = $urandom_range(0, 199) == 0;
      ipValid0   = $urandom_range(0, 3) != 0;
      ipValid1   = $urandom_range(0, 3) != 0;
      ipFIFOFull = $urandom_range(0, 4) == 0;
      ipData0    = 8'($urandom);
      ipData1    = 8'($urandom);
      sample();
      n_cmp++;
      if ({opGrant, opReady1, opReady0, opWriteEnable, opWriteData} !== {eg, er1, er0, ewe, ewd}) begin
        n_bad++; $display("FAIL rand cyc%0d got %b/%h want %b/%h", c, {opGrant, opReady1, opReady0, opWriteEnable}, opWriteData, {eg, er1, er0, ewe}, ewd);
      end
      advance();
    end
    ipReset = 0; ipValid0 = 0; ipValid1 = 0; ipFIFOFull = 0;
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    ipValid0 = 1;
    for (int c = 0; c < 70001; c++) begin
      ipData0 = 8'(c);
      advance();
    end
    ipValid0 = 0;
    sample();
    n_cmp++;
    if (opCount0 !== 16'hFFFF || opCount1 !== 16'h0000) begin
      n_bad++; $display("FAIL stats got %h/%h want ffff/0000", opCount0, opCount1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_full_stall();
    test_reset_mid_burst();
    test_rotation();
    test_random();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
